// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive safety monitor for a Traffic_Light controller.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset (bus ignored, X tolerated)
//   carew      in   a car is waiting on the east-west road
//   lights     in   [5:3] = NS {G,Y,R}, [2:0] = EW {G,Y,R}
//   phase      out  decoded phase of the previous sample (0=GNS,1=YNS,2=GEW,3=YEW)
//   phase_vld  out  previous sample was one of the four legal encodings
//   err        out  sticky violation flag
//   err_code   out  code of the first violation (0 = none)
//   ew_grants  out  saturating count of YNS->GEW entries
//
// Violation codes: 1 illegal encoding, 2 illegal transition, 3 dwell rule,
// 4 east-west starvation, 5 first sample after reset not GNS. When several
// fire on one sample the lowest code is reported. After the first violation
// the monitor halts: the decode keeps tracking, everything else freezes.
module traffic_light_monitor #(
  parameter int YEL_CYC  = 1,
  parameter int GEW_MAX  = 1,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          carew,
  input  logic [5:0]    lights,
  output logic [1:0]    phase,
  output logic          phase_vld,
  output logic          err,
  output logic [2:0]    err_code,
  output logic [CW-1:0] ew_grants
);

  localparam int DW = 16;
  localparam logic [DW-1:0] CNT_MAX   = {DW{1'b1}};
  localparam logic [DW-1:0] CNT_ONE   = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] YEL_W     = DW'(YEL_CYC);
  localparam logic [DW-1:0] GEW_W     = DW'(GEW_MAX);
  localparam logic [DW-1:0] WAIT_W    = DW'(MAX_WAIT);
  localparam logic [CW-1:0] GRANT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] GRANT_ONE = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [5:0] ENC_GNS = 6'b100001;
  localparam logic [5:0] ENC_YNS = 6'b010001;
  localparam logic [5:0] ENC_GEW = 6'b001100;
  localparam logic [5:0] ENC_YEW = 6'b001010;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_GNS  = 3'd1,
    ST_YNS  = 3'd2,
    ST_GEW  = 3'd3,
    ST_YEW  = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  // Counters saturate so a long legal green can never wrap into a false dwell hit.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  state_t          state_q, state_d, dec_state;
  logic [DW-1:0]   dwell_q, dwell_d, wait_q, wait_d;
  logic [DW-1:0]   run_next, wait_next;
  logic [1:0]      phase_q, phase_d, dec_phase;
  logic            phase_vld_q, phase_vld_d, dec_vld;
  logic            err_q, err_d;
  logic [2:0]      err_code_q, err_code_d, first_code;
  logic [CW-1:0]   ew_grants_q, ew_grants_d;
  logic            same, prev_yel, trans_ok;
  logic [4:0]      viol;

  // Decode the bus; case equality so X/Z never matches a legal phase.
  always_comb begin
    dec_vld   = 1'b1;
    dec_phase = 2'd0;
    dec_state = ST_HALT;
    if (lights === ENC_GNS) begin
      dec_phase = 2'd0;
      dec_state = ST_GNS;
    end else if (lights === ENC_YNS) begin
      dec_phase = 2'd1;
      dec_state = ST_YNS;
    end else if (lights === ENC_GEW) begin
      dec_phase = 2'd2;
      dec_state = ST_GEW;
    end else if (lights === ENC_YEW) begin
      dec_phase = 2'd3;
      dec_state = ST_YEW;
    end else begin
      dec_vld   = 1'b0;
      dec_phase = 2'd0;
      dec_state = ST_HALT;
    end
  end

  // Legal successor table: hold, or advance one step round the cycle.
  always_comb begin
    trans_ok = 1'b0;
    case (state_q)
      ST_GNS:  trans_ok = (dec_state == ST_GNS) || (dec_state == ST_YNS);
      ST_YNS:  trans_ok = (dec_state == ST_YNS) || (dec_state == ST_GEW);
      ST_GEW:  trans_ok = (dec_state == ST_GEW) || (dec_state == ST_YEW);
      ST_YEW:  trans_ok = (dec_state == ST_YEW) || (dec_state == ST_GNS);
      default: trans_ok = 1'b0;
    endcase
  end

  // Evaluate every rule against this sample and pick the lowest firing code.
  always_comb begin
    same     = (dec_state == state_q);
    prev_yel = (state_q == ST_YNS) || (state_q == ST_YEW);
    run_next = same ? sat_inc(dwell_q) : CNT_ONE;
    if ((dec_state == ST_GNS) && carew) begin
      wait_next = sat_inc(wait_q);
    end else begin
      wait_next = {DW{1'b0}};
    end

    viol    = 5'b00000;
    viol[0] = !dec_vld;
    if (dec_vld && (state_q == ST_INIT)) begin
      viol[4] = (dec_state != ST_GNS);
    end else if (dec_vld) begin
      viol[1] = !trans_ok;
      // Yellow must last exactly YEL_CYC: flag on exit if short, or on the
      // first over-long sample if held.
      viol[2] = (prev_yel && (same ? (run_next > YEL_W) : (dwell_q != YEL_W))) ||
                ((dec_state == ST_GEW) && (run_next > GEW_W));
      viol[3] = (dec_state == ST_GNS) && (wait_next > WAIT_W);
    end else begin
      viol[4:1] = 4'b0000;
    end

    if (viol[0]) begin
      first_code = 3'd1;
    end else if (viol[1]) begin
      first_code = 3'd2;
    end else if (viol[2]) begin
      first_code = 3'd3;
    end else if (viol[3]) begin
      first_code = 3'd4;
    end else if (viol[4]) begin
      first_code = 3'd5;
    end else begin
      first_code = 3'd0;
    end
  end

  // Next state: decode always tracks; checking state freezes once halted.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    wait_d      = wait_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    ew_grants_d = ew_grants_q;
    phase_d     = dec_phase;
    phase_vld_d = dec_vld;
    if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (first_code != 3'd0) begin
      err_d      = 1'b1;
      err_code_d = first_code;
      state_d    = ST_HALT;
    end else begin
      state_d = dec_state;
      dwell_d = run_next;
      wait_d  = wait_next;
      if ((state_q == ST_YNS) && (dec_state == ST_GEW) && (ew_grants_q != GRANT_MAX)) begin
        ew_grants_d = ew_grants_q + GRANT_ONE;
      end else begin
        ew_grants_d = ew_grants_q;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      dwell_q     <= {DW{1'b0}};
      wait_q      <= {DW{1'b0}};
      phase_q     <= 2'd0;
      phase_vld_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      ew_grants_q <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      wait_q      <= wait_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      ew_grants_q <= ew_grants_d;
    end
  end

  assign phase     = phase_q;
  assign phase_vld = phase_vld_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign ew_grants = ew_grants_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a phase-level
// reference model. A second instance with CW=2 covers counter saturation.
module tb_traffic_light_monitor;

  localparam int YEL = 1;
  localparam int GMAX = 1;
  localparam int MW = 4;

  localparam logic [5:0] L_GNS = 6'b100001;
  localparam logic [5:0] L_YNS = 6'b010001;
  localparam logic [5:0] L_GEW = 6'b001100;
  localparam logic [5:0] L_YEW = 6'b001010;

  logic       clk = 1'b0;
  logic       rst;
  logic       carew;
  logic [5:0] lights;
  logic [1:0] phase, phase2;
  logic       phase_vld, phase_vld2, err, err2;
  logic [2:0] err_code, err_code2;
  logic [7:0] ew_grants;
  logic [1:0] ew_grants2;

  int tests = 0;
  int fails = 0;

  logic [5:0] enc [4] = '{6'b100001, 6'b010001, 6'b001100, 6'b001010};

  traffic_light_monitor #(.YEL_CYC(YEL), .GEW_MAX(GMAX), .MAX_WAIT(MW), .CW(8)) u_dut (
    .clk(clk), .rst(rst), .carew(carew), .lights(lights),
    .phase(phase), .phase_vld(phase_vld), .err(err), .err_code(err_code),
    .ew_grants(ew_grants)
  );

  traffic_light_monitor #(.YEL_CYC(YEL), .GEW_MAX(GMAX), .MAX_WAIT(MW), .CW(2)) u_dut2 (
    .clk(clk), .rst(rst), .carew(carew), .lights(lights),
    .phase(phase2), .phase_vld(phase_vld2), .err(err2), .err_code(err_code2),
    .ew_grants(ew_grants2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase index -1 = nothing seen since reset.
  bit started = 0;
  int m_prev, m_run, m_wt;
  bit m_halt;
  bit exp_vld, exp_err;
  int exp_phase, exp_code, exp_g8, exp_g2;

  always @(posedge clk) begin
    int p, nrun, nwt, code;
    bit same;
    started = 1;
    if (rst) begin
      m_prev = -1; m_run = 0; m_wt = 0; m_halt = 0;
      exp_vld = 0; exp_phase = 0; exp_err = 0; exp_code = 0; exp_g8 = 0; exp_g2 = 0;
    end else begin
      p = -1;
      for (int k = 0; k < 4; k++) if (lights === enc[k]) p = k;
      exp_vld = (p >= 0);
      exp_phase = (p >= 0) ? p : 0;
      if (!m_halt) begin
        same = (p == m_prev);
        nrun = same ? m_run + 1 : 1;
        nwt = (p == 0 && carew === 1'b1) ? m_wt + 1 : 0;
        code = 0;
        if (p < 0) code = 1;
        else if (m_prev < 0) begin
          if (p != 0) code = 5;
        end else begin
          if (!(same || p == (m_prev + 1) % 4)) code = 2;
          else if ((m_prev % 2 == 1) && (same ? (nrun > YEL) : (m_run != YEL))) code = 3;
          else if (p == 2 && nrun > GMAX) code = 3;
          else if (p == 0 && nwt > MW) code = 4;
        end
        if (code != 0) begin
          m_halt = 1; exp_err = 1; exp_code = code;
        end else begin
          if (m_prev == 1 && p == 2) begin
            if (exp_g8 < 255) exp_g8++;
            if (exp_g2 < 3) exp_g2++;
          end
          m_prev = p; m_run = nrun; m_wt = nwt;
        end
      end
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    if (started) begin
      check("phase_vld", 32'(phase_vld), 32'(exp_vld));
      if (exp_vld) check("phase", 32'(phase), 32'(exp_phase));
      check("err", 32'(err), 32'(exp_err));
      check("err_code", 32'(err_code), 32'(exp_code));
      check("ew_grants", 32'(ew_grants), 32'(exp_g8));
      check("err_cw2", 32'(err2), 32'(exp_err));
      check("ew_grants_cw2", 32'(ew_grants2), 32'(exp_g2));
    end
  end

  task automatic step(input logic [5:0] l, input logic c, input logic r);
    lights = l; carew = c; rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] nom [7];
    int nom_ph [7];
    logic [5:0] l;
    logic c;
    int r, dp, halt_cnt;
    nom = '{L_GNS, L_GNS, L_GNS, L_YNS, L_GEW, L_YEW, L_GNS};
    nom_ph = '{0, 0, 0, 1, 2, 3, 0};

    // X on the bus during reset is ignored.
    step(6'bxxxxxx, 1'bx, 1'b1);
    step(6'bxxxxxx, 1'b0, 1'b1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_vld", 32'(phase_vld), 32'd0);
    check("rst_grants", 32'(ew_grants), 32'd0);

    // Nominal cycle.
    for (int i = 0; i < 7; i++) begin
      step(nom[i], 1'b0, 1'b0);
      check("nom_phase", 32'(phase), 32'(nom_ph[i]));
      check("nom_err", 32'(err), 32'd0);
    end
    check("nom_grants", 32'(ew_grants), 32'd1);

    // Illegal encoding latches code 1 and survives later legal traffic.
    step(L_GNS, 1'b0, 1'b1);
    step(L_GNS, 1'b0, 1'b0);
    step(6'b110001, 1'b0, 1'b0);
    check("ill_code", 32'(err_code), 32'd1);
    check("ill_vld", 32'(phase_vld), 32'd0);
    step(L_GNS, 1'b0, 1'b0);
    step(L_YNS, 1'b0, 1'b0);
    check("ill_sticky", 32'(err_code), 32'd1);

    // Skipped yellow.
    step(L_GNS, 1'b0, 1'b1);
    step(L_GNS, 1'b0, 1'b0);
    step(L_GEW, 1'b0, 1'b0);
    check("skip_code", 32'(err_code), 32'd2);
    check("skip_grants", 32'(ew_grants), 32'd0);

    // Long yellow: flagged on the second YNS sample.
    step(L_GNS, 1'b0, 1'b1);
    step(L_GNS, 1'b0, 1'b0);
    step(L_YNS, 1'b0, 1'b0);
    check("longy_ok", 32'(err), 32'd0);
    step(L_YNS, 1'b0, 1'b0);
    check("longy_code", 32'(err_code), 32'd3);

    // Starvation on the fifth waiting GNS sample.
    step(L_GNS, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(L_GNS, 1'b1, 1'b0);
    check("starve_pre", 32'(err), 32'd0);
    step(L_GNS, 1'b1, 1'b0);
    check("starve_code", 32'(err_code), 32'd4);

    // carew drop on cycle 3 restarts the wait.
    step(L_GNS, 1'b0, 1'b1);
    step(L_GNS, 1'b1, 1'b0);
    step(L_GNS, 1'b1, 1'b0);
    step(L_GNS, 1'b0, 1'b0);
    step(L_GNS, 1'b1, 1'b0);
    step(L_GNS, 1'b1, 1'b0);
    check("nostarve", 32'(err), 32'd0);

    // First post-reset sample not GNS.
    step(L_GNS, 1'b0, 1'b1);
    step(L_YEW, 1'b0, 1'b0);
    check("first_code", 32'(err_code), 32'd5);

    // Mid-run reset clears a latched error; nominal cycle afterwards is clean.
    step(L_GNS, 1'b0, 1'b1);
    check("mid_err", 32'(err), 32'd0);
    check("mid_grants", 32'(ew_grants), 32'd0);
    for (int i = 0; i < 7; i++) step(nom[i], 1'b0, 1'b0);
    check("mid_nom_err", 32'(err), 32'd0);
    check("mid_nom_grants", 32'(ew_grants), 32'd1);

    // Saturation of the 2-bit counter.
    step(L_GNS, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(L_GNS, 1'b0, 1'b0);
      step(L_YNS, 1'b0, 1'b0);
      step(L_GEW, 1'b0, 1'b0);
      step(L_YEW, 1'b0, 1'b0);
    end
    check("sat_cw2", 32'(ew_grants2), 32'd3);
    check("sat_cw8", 32'(ew_grants), 32'd5);
    check("sat_err", 32'(err), 32'd0);

    // Randomized traffic: mostly legal cycling with occasional faults and resets.
    dp = 0; halt_cnt = 0;
    step(L_GNS, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 9) < 7);
      if (r < 2 || halt_cnt > 6) begin
        l = ($urandom_range(0, 1) == 1) ? 6'bxxxxxx : 6'($urandom);
        step(l, c, 1'b1);
        dp = 0; halt_cnt = 0;
      end else begin
        if (r < 4) l = 6'($urandom);
        else if (r < 5) l = 6'bxxxxxx;
        else if (r < 8) l = enc[$urandom_range(0, 3)];
        else begin
          l = enc[dp];
          if ((dp == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) != 0))
            dp = (dp + 1) % 4;
        end
        step(l, c, 1'b0);
        if (m_halt) halt_cnt++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
